// File: rtl/pattern_detector.sv
// pattern_detector: serial-bit pattern matcher with runtime-loadable
// pattern/mask, overlapping or non-overlapping detection, match counter.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   en           serial-bit valid; si is sampled only when en=1
//   si           serial data bit (first bit of the sequence ends up in MSB)
//   load         capture pattern_in/mask_in/overlap_in, restart the window
//   pattern_in   new pattern (N bits)
//   mask_in      new compare mask (1 = compare, 0 = don't care)
//   overlap_in   new mode (1 = overlapping, 0 = non-overlapping)
//   count_clr    synchronous clear of match_count
//   detected     registered one-cycle pulse per match
//   match_count  saturating match counter
//   armed        high while the window is full and compares are live

module pattern_detector #(
    parameter int             N             = 3,
    parameter int             CNT_WIDTH     = 8,
    parameter logic [N-1:0]   RESET_PATTERN = N'(3'b110),
    parameter logic [N-1:0]   RESET_MASK    = '1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 si,
    input  logic                 load,
    input  logic [N-1:0]         pattern_in,
    input  logic [N-1:0]         mask_in,
    input  logic                 overlap_in,
    input  logic                 count_clr,
    output logic                 detected,
    output logic [CNT_WIDTH-1:0] match_count,
    output logic                 armed
);

    localparam int FW = $clog2(N + 1);

    localparam logic [FW-1:0] FILL_FULL = FW'(N);
    localparam logic [FW-1:0] FILL_LAST = FW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_HUNT
    } state_t;

    state_t               r_state;
    state_t               w_state_n;
    logic [N-1:0]         r_window;
    logic [N-1:0]         w_window_n;
    logic [FW-1:0]        r_fill;
    logic [FW-1:0]        w_fill_n;
    logic [N-1:0]         r_pattern;
    logic [N-1:0]         r_mask;
    logic                 r_overlap;
    logic                 r_detected;
    logic [CNT_WIDTH-1:0] r_count;

    logic [N-1:0]         w_shifted;
    logic                 w_hit;
    logic                 w_match;
    logic                 w_sat;
    logic                 w_unused_msb;

    // The oldest bit simply falls off the end of the window.
    assign w_unused_msb = r_window[N-1];

    // Compare against the window as it will be after this edge, so the
    // bit being sampled right now takes part in the decision.
    assign w_shifted = {r_window[N-2:0], si};
    assign w_hit     = ((w_shifted ^ r_pattern) & r_mask) == '0;
    assign w_sat     = &r_count;

    always_comb begin
        w_state_n  = r_state;
        w_window_n = r_window;
        w_fill_n   = r_fill;
        w_match    = 1'b0;
        if (load) begin
            // A load restarts detection and drops the bit at this edge.
            w_window_n = '0;
            w_fill_n   = '0;
            w_state_n  = (mask_in == '0) ? S_IDLE : S_FILL;
        end else if (en) begin
            case (r_state)
                S_IDLE: begin
                    w_state_n = S_IDLE;
                end
                S_FILL: begin
                    w_window_n = w_shifted;
                    if (r_fill == FILL_LAST) begin
                        // Nth bit just arrived: its compare already counts.
                        if (w_hit) begin
                            w_match = 1'b1;
                        end
                        if (w_hit && !r_overlap) begin
                            w_fill_n  = '0;
                            w_state_n = S_FILL;
                        end else begin
                            w_fill_n  = FILL_FULL;
                            w_state_n = S_HUNT;
                        end
                    end else begin
                        w_fill_n = r_fill + FW'(1);
                    end
                end
                S_HUNT: begin
                    w_window_n = w_shifted;
                    if (w_hit) begin
                        w_match = 1'b1;
                        if (!r_overlap) begin
                            w_fill_n  = '0;
                            w_state_n = S_FILL;
                        end
                    end
                end
                default: begin
                    w_window_n = '0;
                    w_fill_n   = '0;
                    w_state_n  = S_FILL;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_FILL;
            r_window <= '0;
            r_fill   <= '0;
        end else begin
            r_state  <= w_state_n;
            r_window <= w_window_n;
            r_fill   <= w_fill_n;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pattern <= RESET_PATTERN;
            r_mask    <= RESET_MASK;
            r_overlap <= 1'b1;
        end else if (load) begin
            r_pattern <= pattern_in;
            r_mask    <= mask_in;
            r_overlap <= overlap_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_detected <= 1'b0;
        end else begin
            r_detected <= w_match;
        end
    end

    // Clear beats a coincident match; the pulse itself is unaffected.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (count_clr) begin
            r_count <= '0;
        end else if (w_match && !w_sat) begin
            r_count <= r_count + CNT_WIDTH'(1);
        end
    end

    assign detected    = r_detected;
    assign match_count = r_count;
    assign armed       = (r_state == S_HUNT);

endmodule
